sevenseg_scan_decoder: RTL and testbench
========================================

Name: sevenseg_scan_decoder

Overview:
- Receive-side decoder for the 8-digit multiplexed seven-segment interface (active-low seg[6:0] = {g,f,e,d,c,b,a}, active-low one-hot an[7:0]).
- Watches the scanned seg/an lines, rejects transitional glitches with a stability filter, converts each settled pattern back to a hex nibble and assembles a full 32-bit frame.
- Used as a loopback checker or on-chip monitor behind the display driver.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 2..255.
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous reset, active-high
- seg  input  7  active-low segment lines {g,f,e,d,c,b,a}
- an  input  8  active-low anode enables; an[i]=0 selects digit i
- digit_valid  output  8  bit i set once digit i has been captured in the current frame
- frame_value  output  32  last completed frame; digit i occupies bits [4i+3:4i]
- frame_done  output  1  one-cycle pulse when frame_value updates
- bad_pattern  output  1  one-cycle pulse: settled seg is not one of the 16 hex glyphs
- bad_anode  output  1  one-cycle pulse: settled an is neither one-hot-low nor 8'hFF
- err_count  output  8  saturating error count (see Optional Feature)

Behaviour:
- Reset values: digit_valid=0, frame_value=0, frame_done=0, bad_pattern=0, bad_anode=0, err_count=0, stability counter=0, FSM=SETTLE, internal digit buffer=0.
- seg and an are registered every cycle into a sample register. The stability counter tracks that registered sample: it clears when the sample differs from the previous sample, otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLE: counting. When the counter reaches STABLE_CYCLES-1 with the sample unchanged, perform one evaluation and move to HOLD.
  - HOLD: no further evaluation. Any change in the sample returns the FSM to SETTLE with counter=0.
- Exactly one evaluation happens per dwell, regardless of how long the dwell lasts.
- Latency: if seg/an change before edge 0 and are then held, the evaluation result is visible after edge STABLE_CYCLES.
- Evaluation:
  - an==8'hFF (blanked): no action, no error.
  - an one-hot-low (digit i) and seg is a valid glyph: write the nibble to buffer slot i and set digit_valid[i].
  - Glyph map, seg value for 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit).
  - an one-hot-low and seg not in the map: bad_pattern pulse; slot i and digit_valid unchanged.
  - Any other an value: bad_anode pulse; seg is ignored.
- Re-capture of a digit whose digit_valid is already 1: the nibble is overwritten and frame progress is unchanged.
- Frame completion: on the edge where a capture would make digit_valid all ones:
  - frame_value is loaded with the buffer including the new nibble;
  - frame_done is 1 for the following cycle;
  - digit_valid is cleared to 0 at that same edge.
  - digit_valid therefore never reads 8'hFF.
- frame_value holds its value until the next completion.
- Only one evaluation happens per cycle, so bad_pattern, bad_anode and frame_done are mutually exclusive.
- rst asserted mid-dwell or mid-frame discards the partial frame; all state returns to reset values on that edge.

Optional Feature:
- Macro SEVENSEG_DEC_ERRCNT_EN.
- Defined: err_count increments by 1 on each bad_pattern or bad_anode pulse and saturates at 8'hFF. It clears only on rst.
- Undefined: no counter logic is built and err_count is tied to 8'h00. Port list is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with seg=7'h00, an=8'h00 → all outputs 0. First evaluation occurs only STABLE_CYCLES cycles after rst deasserts.
- Full frame: drive digit i=0..7 with glyphs for 1,2,3,4,5,6,7,8, each held 10 cycles, STABLE_CYCLES=4.
  - Expect frame_done one pulse after the 8th dwell, frame_value=32'h87654321.
  - Expect digit_valid=0 on that cycle, and digit_valid steps 01,03,…,7F before it.
- Glitch rejection: present an=8'hFE with seg=7'h79 for 3 cycles, then change to seg=7'h24 held 6 cycles → only nibble 2 captured in slot 0, digit_valid=8'h01, no error pulse.
- Errors:
  - an=8'hFD, seg=7'h7F held 6 cycles → one bad_pattern pulse, digit_valid unchanged.
  - an=8'hFC held 6 cycles → one bad_anode pulse.
  - an=8'hFF → no pulse.
  - With SEVENSEG_DEC_ERRCNT_EN, err_count=2 afterwards; forcing 300 errors leaves err_count=8'hFF.
- Recapture and long dwell: digit 3 held 50 cycles → exactly one capture; then digit 3 again with seg=7'h0E → slot 3 holds F, digit_valid popcount unchanged.
- Reset mid-frame: capture digits 0..5, assert rst 1 cycle, then capture all 8 with 9,A,B,C,D,E,F,0.
  - Expect frame_value=32'h0FEDCBA9 and no stale nibbles.

Source files
------------

// File: rtl/sevenseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_decoder
//
// Receive-side decoder for an 8-digit multiplexed seven-segment display bus.
// It watches the scanned segment/anode lines and waits for each pattern to
// settle. It then turns the settled glyph back into a hex nibble and assembles
// the 8 nibbles into a 32-bit frame.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous reset, active-high
//   seg          in   7   active-low segments {g,f,e,d,c,b,a}
//   an           in   8   active-low anode enables, an[i]=0 selects digit i
//   digit_valid  out  8   bit i set once digit i captured in current frame
//   frame_value  out  32  last completed frame, digit i at [4i+3:4i]
//   frame_done   out  1   one-cycle pulse when frame_value updates
//   bad_pattern  out  1   one-cycle pulse: settled seg is not a hex glyph
//   bad_anode    out  1   one-cycle pulse: settled an not one-hot-low/blank
//   err_count    out  8   saturating error counter (optional)
//
// Optional feature macro: SEVENSEG_DEC_ERRCNT_EN
//   defined   -> err_count counts bad_pattern/bad_anode pulses, saturating
//   undefined -> err_count tied to 8'h00
//
// Handshake: none. The inputs are free-running scan lines, and every output is
// a registered level or a one-cycle pulse.
// -----------------------------------------------------------------------------
module sevenseg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [7:0]  an,
  output logic [7:0]  digit_valid,
  output logic [31:0] frame_value,
  output logic        frame_done,
  output logic        bad_pattern,
  output logic        bad_anode,
  output logic [7:0]  err_count
);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  // The reset sample is the idle/blank bus. A real pattern presented after
  // reset is therefore seen as a fresh change. Its first evaluation then lands
  // STABLE_CYCLES edges later, like any other dwell.
  localparam logic [6:0] SEG_IDLE = 7'h7F;
  localparam logic [7:0] AN_IDLE  = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_EVAL = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       samp_seg_q;
  logic [7:0]       samp_an_q;
  logic [31:0]      buf_q;
  logic [7:0]       digit_valid_q;
  logic [31:0]      frame_value_q;
  logic             frame_done_q;
  logic             bad_pattern_q;
  logic             bad_anode_q;

  // Glyph to {valid, nibble}
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic        changed;
  logic        eval_fire;
  logic [7:0]  sel;
  logic        sel_onehot;
  logic        is_blank;
  logic [2:0]  idx;
  logic [4:0]  dec;
  logic [7:0]  valid_next;
  logic [31:0] buf_next;
  logic        err_pulse;

  always_comb begin
    changed    = ({seg, an} != {samp_seg_q, samp_an_q});
    // An evaluation happens on the edge that would bring the counter to
    // STABLE_CYCLES while still in SETTLE. It happens once per dwell because
    // the FSM then moves to HOLD.
    eval_fire  = !changed && (state_q == SETTLE) && (cnt_q == CNT_EVAL);
    sel        = ~samp_an_q;
    is_blank   = (samp_an_q == 8'hFF);
    sel_onehot = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    idx        = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) idx = 3'(i);
    end
    dec        = glyph_decode(samp_seg_q);
    valid_next = digit_valid_q | (8'b1 << idx);
    buf_next   = buf_q;
    buf_next[{idx, 2'b00} +: 4] = dec[3:0];
    err_pulse  = eval_fire && !is_blank && (!sel_onehot || !dec[4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SETTLE;
      cnt_q         <= '0;
      samp_seg_q    <= SEG_IDLE;
      samp_an_q     <= AN_IDLE;
      buf_q         <= '0;
      digit_valid_q <= '0;
      frame_value_q <= '0;
      frame_done_q  <= 1'b0;
      bad_pattern_q <= 1'b0;
      bad_anode_q   <= 1'b0;
    end else begin
      samp_seg_q    <= seg;
      samp_an_q     <= an;
      frame_done_q  <= 1'b0;
      bad_pattern_q <= 1'b0;
      bad_anode_q   <= 1'b0;

      if (changed) begin
        cnt_q   <= '0;
        state_q <= SETTLE;
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        case (state_q)
          SETTLE: begin
            if (eval_fire) begin
              state_q <= HOLD;
              if (is_blank) begin
                // Blanked bus: nothing to capture.
              end else if (!sel_onehot) begin
                bad_anode_q <= 1'b1;
              end else if (!dec[4]) begin
                bad_pattern_q <= 1'b1;
              end else begin
                buf_q <= buf_next;
                if (valid_next == 8'hFF) begin
                  frame_value_q <= buf_next;
                  frame_done_q  <= 1'b1;
                  digit_valid_q <= '0;
                end else begin
                  digit_valid_q <= valid_next;
                end
              end
            end
          end
          HOLD: begin
            // Wait for the bus to move on.
          end
          default: state_q <= SETTLE;
        endcase
      end
    end
  end

`ifdef SEVENSEG_DEC_ERRCNT_EN
  logic [7:0] err_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (err_pulse && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end
  assign err_count = err_count_q;
`else
  logic unused_err;
  assign unused_err = err_pulse;
  assign err_count  = 8'h00;
`endif

  assign digit_valid = digit_valid_q;
  assign frame_value = frame_value_q;
  assign frame_done  = frame_done_q;
  assign bad_pattern = bad_pattern_q;
  assign bad_anode   = bad_anode_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
module tb_sevenseg_scan_decoder;

  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [7:0]  an  = 8'hFF;
  logic [7:0]  digit_valid;
  logic [31:0] frame_value;
  logic        frame_done;
  logic        bad_pattern;
  logic        bad_anode;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  sevenseg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digit_valid (digit_valid),
    .frame_value (frame_value),
    .frame_done  (frame_done),
    .bad_pattern (bad_pattern),
    .bad_anode   (bad_anode),
    .err_count   (err_count)
  );

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_have [8];
  logic [3:0]  m_nib  [8];
  logic [31:0] m_frame;
  int          m_err;
  logic [14:0] prev_in;

  int n_checks = 0;
  int n_errors = 0;
  int fd_seen = 0, bp_seen = 0, ba_seen = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_have[i] = 1'b0;
      m_nib[i]  = 4'h0;
    end
    m_frame = 32'h0;
    m_err   = 0;
    prev_in = {7'h7F, 8'hFF};
  endtask

  // One evaluation of a settled pattern, stated directly from the rules.
  task automatic model_eval(input logic [6:0] s, input logic [7:0] a,
                            output bit fd, output bit bp, output bit ba);
    int zeros, pos, val;
    bit all;
    fd = 0; bp = 0; ba = 0;
    if (a == 8'hFF) return;
    zeros = 0; pos = 0;
    for (int i = 0; i < 8; i++) if (a[i] == 1'b0) begin zeros++; pos = i; end
    if (zeros != 1) begin ba = 1; m_err++; return; end
    val = -1;
    for (int v = 0; v < 16; v++) if (glyph_tab[v] == s) val = v;
    if (val < 0) begin bp = 1; m_err++; return; end
    m_nib[pos]  = 4'(val);
    m_have[pos] = 1'b1;
    all = 1;
    for (int i = 0; i < 8; i++) if (!m_have[i]) all = 0;
    if (all) begin
      for (int i = 0; i < 8; i++) begin
        m_frame[i*4 +: 4] = m_nib[i];
        m_have[i] = 1'b0;
      end
      fd = 1;
    end
  endtask

  function automatic logic [7:0] exp_valid();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m_have[i];
    return r;
  endfunction

  function automatic logic [7:0] exp_err();
`ifdef SEVENSEG_DEC_ERRCNT_EN
    return (m_err > 255) ? 8'hFF : 8'(m_err);
`else
    return 8'h00;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Hold one pattern for len cycles and compare every output after each edge.
  task automatic dwell(input logic [6:0] s, input logic [7:0] a, input int len);
    bit fd, bp, ba;
    if ({s, a} == prev_in) begin
      // Break the merge with a one-cycle blank, which is too short to evaluate.
      seg = s ^ 7'h01; an = 8'hFF;
      @(posedge clk); #1;
    end
    seg = s; an = a;
    prev_in = {s, a};
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      fd = 0; bp = 0; ba = 0;
      if (k == S) model_eval(s, a, fd, bp, ba);
      if (frame_done) fd_seen++;
      if (bad_pattern) bp_seen++;
      if (bad_anode) ba_seen++;
      n_checks += 6;
      if (digit_valid !== exp_valid()) begin
        n_errors++;
        $display("FAIL digit_valid t=%0t got %h exp %h", $time, digit_valid, exp_valid());
      end
      if (frame_value !== m_frame) begin
        n_errors++;
        $display("FAIL frame_value t=%0t got %h exp %h", $time, frame_value, m_frame);
      end
      if (frame_done !== fd) begin
        n_errors++;
        $display("FAIL frame_done t=%0t got %b exp %b", $time, frame_done, fd);
      end
      if (bad_pattern !== bp) begin
        n_errors++;
        $display("FAIL bad_pattern t=%0t got %b exp %b", $time, bad_pattern, bp);
      end
      if (bad_anode !== ba) begin
        n_errors++;
        $display("FAIL bad_anode t=%0t got %b exp %b", $time, bad_anode, ba);
      end
      if (err_count !== exp_err()) begin
        n_errors++;
        $display("FAIL err_count t=%0t got %h exp %h", $time, err_count, exp_err());
      end
    end
  endtask

  function automatic logic [7:0] an_of(input int d);
    return ~(8'b1 << d);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int ba0;
    seg = 7'h00; an = 8'h00;
    do_reset(2);
    n_checks++;
    if ({digit_valid, frame_value, frame_done, bad_pattern, bad_anode, err_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got dv=%h fv=%h fd=%b bp=%b ba=%b ec=%h exp all zero",
               digit_valid, frame_value, frame_done, bad_pattern, bad_anode, err_count);
    end
    ba0 = ba_seen;
    dwell(7'h00, 8'h00, 6);
    n_checks++;
    if (ba_seen - ba0 != 1) begin
      n_errors++;
      $display("FAIL reset_first_eval got %0d bad_anode pulses exp 1", ba_seen - ba0);
    end
  endtask

  task automatic test_full_frame();
    int fd0;
    logic [7:0] e;
    do_reset(2);
    fd0 = fd_seen;
    for (int i = 0; i < 8; i++) begin
      dwell(glyph_tab[i+1], an_of(i), 10);
      if (i < 7) begin
        e = 8'hFF >> (7 - i);
        n_checks++;
        if (digit_valid !== e) begin
          n_errors++;
          $display("FAIL full_frame_step%0d got %h exp %h", i, digit_valid, e);
        end
      end
    end
    n_checks += 3;
    if (frame_value !== 32'h87654321) begin
      n_errors++;
      $display("FAIL full_frame_value got %h exp 87654321", frame_value);
    end
    if (fd_seen - fd0 != 1) begin
      n_errors++;
      $display("FAIL full_frame_done got %0d pulses exp 1", fd_seen - fd0);
    end
    if (digit_valid !== 8'h00) begin
      n_errors++;
      $display("FAIL full_frame_dv_clear got %h exp 00", digit_valid);
    end
  endtask

  task automatic test_glitch();
    int e0;
    do_reset(2);
    e0 = bp_seen + ba_seen;
    dwell(7'h79, 8'hFE, 3);
    dwell(7'h24, 8'hFE, 6);
    n_checks += 2;
    if (digit_valid !== 8'h01) begin
      n_errors++;
      $display("FAIL glitch_dv got %h exp 01", digit_valid);
    end
    if (bp_seen + ba_seen != e0) begin
      n_errors++;
      $display("FAIL glitch_err got %0d pulses exp 0", bp_seen + ba_seen - e0);
    end
    for (int i = 1; i < 8; i++) dwell(glyph_tab[0], an_of(i), 6);
    n_checks++;
    if (frame_value !== 32'h00000002) begin
      n_errors++;
      $display("FAIL glitch_frame got %h exp 00000002", frame_value);
    end
  endtask

  task automatic test_errors();
    int bp0, ba0;
    do_reset(2);
    bp0 = bp_seen; ba0 = ba_seen;
    dwell(7'h7F, 8'hFD, 6);
    n_checks += 2;
    if (bp_seen - bp0 != 1) begin
      n_errors++;
      $display("FAIL err_pattern got %0d pulses exp 1", bp_seen - bp0);
    end
    if (digit_valid !== 8'h00) begin
      n_errors++;
      $display("FAIL err_pattern_dv got %h exp 00", digit_valid);
    end
    dwell(7'h40, 8'hFC, 6);
    n_checks++;
    if (ba_seen - ba0 != 1) begin
      n_errors++;
      $display("FAIL err_anode got %0d pulses exp 1", ba_seen - ba0);
    end
    dwell(7'h40, 8'hFF, 6);
    n_checks += 2;
    if ((bp_seen - bp0) + (ba_seen - ba0) != 2) begin
      n_errors++;
      $display("FAIL err_blank got %0d total pulses exp 2", (bp_seen - bp0) + (ba_seen - ba0));
    end
`ifdef SEVENSEG_DEC_ERRCNT_EN
    if (err_count !== 8'd2) begin
      n_errors++;
      $display("FAIL err_count_two got %h exp 02", err_count);
    end
`else
    if (err_count !== 8'd0) begin
      n_errors++;
      $display("FAIL err_count_off got %h exp 00", err_count);
    end
`endif
  endtask

  task automatic test_recapture();
    do_reset(2);
    dwell(glyph_tab[4], an_of(3), 50);
    n_checks++;
    if (digit_valid !== 8'h08) begin
      n_errors++;
      $display("FAIL recap_long got %h exp 08", digit_valid);
    end
    dwell(7'h0E, an_of(3), 6);
    n_checks++;
    if (digit_valid !== 8'h08) begin
      n_errors++;
      $display("FAIL recap_dv got %h exp 08", digit_valid);
    end
    for (int i = 0; i < 8; i++) if (i != 3) dwell(glyph_tab[0], an_of(i), 6);
    n_checks++;
    if (frame_value !== 32'h0000F000) begin
      n_errors++;
      $display("FAIL recap_frame got %h exp 0000F000", frame_value);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(2);
    for (int i = 0; i < 6; i++) dwell(glyph_tab[7 - i], an_of(i), 6);
    do_reset(1);
    n_checks++;
    if (digit_valid !== 8'h00) begin
      n_errors++;
      $display("FAIL midrst_dv got %h exp 00", digit_valid);
    end
    for (int i = 0; i < 8; i++) dwell(glyph_tab[(9 + i) % 16], an_of(i), 6);
    n_checks++;
    if (frame_value !== 32'h0FEDCBA9) begin
      n_errors++;
      $display("FAIL midrst_frame got %h exp 0FEDCBA9", frame_value);
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [7:0] a;
    int unsigned kind;
    do_reset(2);
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 8'hFF;
      else if (kind == 1) a = 8'($urandom);
      else                a = an_of($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) s = 7'($urandom);
      else                           s = glyph_tab[$urandom_range(0, 15)];
      dwell(s, a, $urandom_range(1, 12));
    end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 300; n++) dwell(7'h40, (n % 2 == 0) ? 8'hFC : 8'hF3, S + 1);
    n_checks++;
`ifdef SEVENSEG_DEC_ERRCNT_EN
    if (err_count !== 8'hFF) begin
      n_errors++;
      $display("FAIL err_saturate got %h exp FF", err_count);
    end
`else
    if (err_count !== 8'h00) begin
      n_errors++;
      $display("FAIL err_saturate got %h exp 00", err_count);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_full_frame();
    test_glitch();
    test_errors();
    test_recapture();
    test_reset_mid_frame();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
